// File: rtl/simple_tx_drain.sv
// rtl/simple_tx_drain.sv - drains the TX FIFO into a valid/ready stream with an inter-packet gap
// Optional statistics counters (pkt_count, word_count) are built when TX_DRAIN_STATS_EN is defined.
module simple_tx_drain #(
   parameter int DATA_WIDTH = 64,
   parameter int IFG_CYCLES = 2,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [DATA_WIDTH:0]   fifo_dout,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   output logic [DATA_WIDTH-1:0] m_tdata,
   output logic                  m_tlast,
   output logic                  m_tvalid,
   input  logic                  m_tready,
   output logic                  tx_busy
`ifdef TX_DRAIN_STATS_EN
   ,
   output logic [CNT_WIDTH-1:0]  pkt_count,
   output logic [CNT_WIDTH-1:0]  word_count
`endif
);

   localparam int GAP_W = (IFG_CYCLES > 0) ? $clog2(IFG_CYCLES + 1) : 1;
   localparam logic [GAP_W-1:0] GAP_LOAD = (IFG_CYCLES > 0) ? GAP_W'(IFG_CYCLES - 1) : '0;

   typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

   state_t            state;
   logic [GAP_W-1:0]  gap_cnt;
   logic [1:0]        occ;
   logic              inflight;
   logic [DATA_WIDTH:0] head;
   logic [DATA_WIDTH:0] tail;
   logic              handshake;

   assign m_tdata   = head[DATA_WIDTH-1:0];
   assign m_tlast   = head[DATA_WIDTH];
   assign m_tvalid  = (occ != 2'd0) && (state != GAP);
   assign handshake = m_tvalid & m_tready;
   assign tx_busy   = (state != IDLE);

   // Credit counts the word still in the FIFO's output register, so capture never overflows the buffer.
   assign fifo_rd_en = ~reset & ~fifo_empty & (({1'b0, occ} + {2'b00, inflight}) < 3'd2);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         occ      <= 2'd0;
         inflight <= 1'b0;
         head     <= '0;
         tail     <= '0;
      end else begin
         inflight <= fifo_rd_en;
         case ({inflight, handshake})
            2'b10: begin
               if (occ == 2'd0) head <= fifo_dout;
               else             tail <= fifo_dout;
               occ <= occ + 2'd1;
            end
            2'b01: begin
               head <= tail;
               occ  <= occ - 2'd1;
            end
            2'b11: begin
               if (occ == 2'd1) begin
                  head <= fifo_dout;
               end else begin
                  head <= tail;
                  tail <= fifo_dout;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         gap_cnt <= '0;
      end else begin
         case (state)
            IDLE, XFER: begin
               if (handshake) begin
                  if (m_tlast) begin
                     if (IFG_CYCLES > 0) begin
                        state   <= GAP;
                        gap_cnt <= GAP_LOAD;
                     end else begin
                        state <= IDLE;
                     end
                  end else begin
                     state <= XFER;
                  end
               end
            end
            GAP: begin
               if (gap_cnt == '0) state <= IDLE;
               else               gap_cnt <= gap_cnt - 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef TX_DRAIN_STATS_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pkt_count  <= '0;
         word_count <= '0;
      end else if (handshake) begin
         word_count <= word_count + 1'b1;
         if (m_tlast) pkt_count <= pkt_count + 1'b1;
      end
   end
`endif

endmodule
